error_detector: RTL and testbench

ERROR_DETECTOR -- requirements
Module: error_detector

---
 rtl/ft_pkg.sv | 30 +++
 rtl/skew_fifo.sv | 49 ++++
 rtl/error_detector.sv | 146 ++++++++++++++
 tb/tb_error_detector.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// Shared types for the lockstep error detector: retire-entry tuple, error cause
// codes and detector FSM states.
package ft_pkg;

  // Entry fields are sized for the widest supported configuration; narrower
  // register indices and data are zero-extended on entry.
  localparam int RE_PC_W   = 32;
  localparam int RE_ADDR_W = 8;
  localparam int RE_DATA_W = 64;

  typedef struct packed {
    logic [RE_PC_W-1:0]   pc;
    logic [RE_ADDR_W-1:0] waddr;
    logic [RE_DATA_W-1:0] wdata;
  } retire_entry_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISMATCH = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_OVERFLOW = 2'b11
  } err_cause_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLAG    = 2'd1,
    ST_BLOCKED = 2'd2
  } det_state_e;

endpackage

// File: rtl/skew_fifo.sv
// Per-core skew buffer: retire tuples queue here until the other core catches up.
// A push into a full buffer is dropped unless a pop frees the slot in the same cycle.
module skew_fifo
  import ft_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  retire_entry_t i_data,
  input  logic          i_pop,
  output retire_entry_t o_head,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  retire_entry_t  r_mem [DEPTH];
  logic [PTR_W:0] r_wptr;
  logic [PTR_W:0] r_rptr;
  logic           w_do_push;
  logic           w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]) &&
                     (r_wptr[PTR_W] != r_rptr[PTR_W]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rptr[PTR_W-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[PTR_W-1:0]] <= i_data;
  end

endmodule

// File: rtl/error_detector.sv
// Lockstep retire comparator: buffers both cores' retire streams, compares them
// in order and raises mismatch/timeout/overflow errors. Macro: FT_ERR_COUNTER_EN.
module error_detector
  import ft_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_a_i,
  input  logic                  valid_b_i,
  input  logic [31:0]           pc_a_i,
  input  logic [31:0]           pc_b_i,
  input  logic [ADDR_WIDTH-1:0] waddr_a_i,
  input  logic [ADDR_WIDTH-1:0] waddr_b_i,
  input  logic [DATA_WIDTH-1:0] wdata_a_i,
  input  logic [DATA_WIDTH-1:0] wdata_b_i,
  input  logic                  resume_i,
  output logic                  error_o,
  output logic [1:0]            err_cause_o,
  output logic [15:0]           error_count_o,
  output det_state_e            dbg_state_o
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  det_state_e      r_state;
  det_state_e      w_state_next;
  err_cause_e      r_cause;
  err_cause_e      w_cause;
  logic [TO_W-1:0] r_to_cnt;

  retire_entry_t w_in_a;
  retire_entry_t w_in_b;
  retire_entry_t w_head_a;
  retire_entry_t w_head_b;
  logic          w_full_a;
  logic          w_full_b;
  logic          w_empty_a;
  logic          w_empty_b;
  logic          w_run;
  logic          w_flush;
  logic          w_push_a;
  logic          w_push_b;
  logic          w_both;
  logic          w_pop;
  logic          w_one_sided;
  logic          w_mismatch;
  logic          w_timeout;
  logic          w_overflow;
  logic          w_any_err;

  assign w_in_a = '{pc: pc_a_i, waddr: RE_ADDR_W'(waddr_a_i), wdata: RE_DATA_W'(wdata_a_i)};
  assign w_in_b = '{pc: pc_b_i, waddr: RE_ADDR_W'(waddr_b_i), wdata: RE_DATA_W'(wdata_b_i)};

  // Retire strobes are valid-only with no backpressure: a tuple is taken on every
  // cycle valid is high while running; a push the buffer cannot hold is an overflow.
  assign w_run    = (r_state == ST_RUN);
  assign w_flush  = !w_run;
  assign w_push_a = valid_a_i && w_run;
  assign w_push_b = valid_b_i && w_run;

  skew_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_flush (w_flush),
    .i_push  (w_push_a),
    .i_data  (w_in_a),
    .i_pop   (w_pop),
    .o_head  (w_head_a),
    .o_full  (w_full_a),
    .o_empty (w_empty_a)
  );

  skew_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_flush (w_flush),
    .i_push  (w_push_b),
    .i_data  (w_in_b),
    .i_pop   (w_pop),
    .o_head  (w_head_b),
    .o_full  (w_full_b),
    .o_empty (w_empty_b)
  );

  assign w_both      = !w_empty_a && !w_empty_b;
  assign w_pop       = w_run && w_both && (w_head_a == w_head_b);
  assign w_mismatch  = w_run && w_both && (w_head_a != w_head_b);
  assign w_one_sided = w_empty_a ^ w_empty_b;
  // Fires on the TIMEOUT-th consecutive one-sided cycle.
  assign w_timeout   = w_run && w_one_sided && (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign w_overflow  = (w_push_a && w_full_a && !w_pop) ||
                       (w_push_b && w_full_b && !w_pop);
  assign w_any_err   = w_overflow || w_mismatch || w_timeout;

  always_comb begin
    w_state_next = r_state;
    w_cause      = CAUSE_NONE;
    if (w_overflow)      w_cause = CAUSE_OVERFLOW;
    else if (w_mismatch) w_cause = CAUSE_MISMATCH;
    else if (w_timeout)  w_cause = CAUSE_TIMEOUT;
    case (r_state)
      ST_RUN:     if (w_any_err) w_state_next = ST_FLAG;
      ST_FLAG:    w_state_next = ST_BLOCKED;
      ST_BLOCKED: if (resume_i) w_state_next = ST_RUN;
      default:    w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_state_next;
      if (w_run && w_any_err) r_cause <= w_cause;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !w_run || !w_one_sided) r_to_cnt <= '0;
    else                                 r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign error_o     = (r_state == ST_FLAG);
  assign err_cause_o = error_o ? r_cause : CAUSE_NONE;
  assign dbg_state_o = r_state;

`ifdef FT_ERR_COUNTER_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)                                         r_err_cnt <= '0;
    else if (error_o && (r_err_cnt != 16'hFFFF))       r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign error_count_o = r_err_cnt;
`else
  assign error_count_o = '0;
`endif

endmodule

// File: tb/tb_error_detector.sv
// Bench for error_detector: directed vector table, hand sequences for multi-cycle
// corners, and randomized retire streams checked against a queue-based model.
module tb_error_detector;
  import ft_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int TO    = 8;
  localparam int NVEC  = 52;

  typedef struct packed {
    logic [31:0]   pc;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } tup_t;

  typedef struct {
    logic rst;
    logic va;
    logic vb;
    logic resume;
    tup_t ta;
    tup_t tb;
  } in_t;

  typedef struct {
    in_t        stim;
    logic       exp_err;
    logic [1:0] exp_cause;
    det_state_e exp_st;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          valid_a, valid_b, resume;
  logic [31:0]   pc_a, pc_b;
  logic [AW-1:0] waddr_a, waddr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          error_o;
  logic [1:0]    err_cause;
  logic [15:0]   err_count;
  det_state_e    dut_state;

  error_detector #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .valid_a_i     (valid_a),
    .valid_b_i     (valid_b),
    .pc_a_i        (pc_a),
    .pc_b_i        (pc_b),
    .waddr_a_i     (waddr_a),
    .waddr_b_i     (waddr_b),
    .wdata_a_i     (wdata_a),
    .wdata_b_i     (wdata_b),
    .resume_i      (resume),
    .error_o       (error_o),
    .err_cause_o   (err_cause),
    .error_count_o (err_count),
    .dbg_state_o   (dut_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: per-core queues, phase 0=running 1=pulsing 2=halted
  tup_t       qa[$];
  tup_t       qb[$];
  int         m_phase = 0;
  logic [1:0] m_cause = 2'b00;
  int         m_one   = 0;
  int         m_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v.rst = 1'b0; v.va = 1'b0; v.vb = 1'b0; v.resume = 1'b0;
    v.ta = '0; v.tb = '0;
    return v;
  endfunction

  function automatic tup_t mk(input logic [31:0] pc, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    tup_t t;
    t.pc = pc; t.wa = wa; t.wd = wd;
    return t;
  endfunction

  function automatic tup_t gen(input int k);
    logic [31:0] kk;
    tup_t t;
    kk = k;
    t.pc = 32'h1000 + (kk << 2);
    t.wa = kk[AW-1:0];
    t.wd = kk * 32'h9E37_79B1;
    return t;
  endfunction

  task automatic model_step(input in_t v);
    bit pop, mis, ovf, tmo, one;
    if (v.rst) begin
      qa.delete(); qb.delete();
      m_phase = 0; m_one = 0; m_cnt = 0; m_cause = 2'b00;
      return;
    end
    case (m_phase)
      0: begin
        pop = 0; mis = 0;
        if (qa.size() > 0 && qb.size() > 0) begin
          if (qa[0] == qb[0]) pop = 1;
          else                mis = 1;
        end
        one = (qa.size() > 0) != (qb.size() > 0);
        tmo = one && (m_one + 1 >= TO);
        ovf = (v.va && qa.size() == DEPTH && !pop) || (v.vb && qb.size() == DEPTH && !pop);
        if (pop) begin
          void'(qa.pop_front());
          void'(qb.pop_front());
        end
        if (v.va && qa.size() < DEPTH) qa.push_back(v.ta);
        if (v.vb && qb.size() < DEPTH) qb.push_back(v.tb);
        m_one = one ? m_one + 1 : 0;
        if (ovf)      begin m_cause = 2'b11; m_phase = 1; end
        else if (mis) begin m_cause = 2'b01; m_phase = 1; end
        else if (tmo) begin m_cause = 2'b10; m_phase = 1; end
      end
      1: begin
        qa.delete(); qb.delete(); m_one = 0;
        if (m_cnt < 65535) m_cnt++;
        m_phase = 2;
      end
      default: begin
        qa.delete(); qb.delete(); m_one = 0;
        if (v.resume) m_phase = 0;
      end
    endcase
  endtask

  // driver: apply one cycle of stimulus, compare against the model, advance it
  task automatic do_cycle(input in_t v, input string tag);
    det_state_e e_st;
    logic [15:0] e_cnt;
    @(negedge clk);
    rst = v.rst; resume = v.resume;
    valid_a = v.va; pc_a = v.ta.pc; waddr_a = v.ta.wa; wdata_a = v.ta.wd;
    valid_b = v.vb; pc_b = v.tb.pc; waddr_b = v.tb.wa; wdata_b = v.tb.wd;
    #1;
    e_st = (m_phase == 0) ? ST_RUN : (m_phase == 1) ? ST_FLAG : ST_BLOCKED;
`ifdef FT_ERR_COUNTER_EN
    e_cnt = 16'(m_cnt);
`else
    e_cnt = 16'd0;
`endif
    check({tag, ".err"},   32'(error_o),   32'(m_phase == 1));
    check({tag, ".cause"}, 32'(err_cause), (m_phase == 1) ? 32'(m_cause) : 32'd0);
    check({tag, ".count"}, 32'(err_count), 32'(e_cnt));
    check({tag, ".state"}, 32'(dut_state), 32'(e_st));
    check({tag, ".empty_a"}, 32'(dut.w_empty_a), 32'(qa.size() == 0));
    check({tag, ".empty_b"}, 32'(dut.w_empty_b), 32'(qb.size() == 0));
    model_step(v);
  endtask

  vec_t tbl[NVEC];

  initial begin
    in_t  v;
    tup_t t_id, m_a, m_b;
    int   ia, ib;

    t_id = mk(32'h100, 5'd3, 32'hDEAD);
    m_a  = mk(32'h100, 5'd3, 32'h1);
    m_b  = mk(32'h100, 5'd3, 32'h2);

    // directed vector table
    for (int i = 0; i < NVEC; i++) begin
      tbl[i].stim = idle(); tbl[i].exp_err = 1'b0;
      tbl[i].exp_cause = 2'b00; tbl[i].exp_st = ST_RUN;
    end
    tbl[0].stim.rst = 1'b1;
    tbl[1].stim.va = 1'b1; tbl[1].stim.ta = t_id; tbl[1].stim.vb = 1'b1; tbl[1].stim.tb = t_id;
    tbl[4].stim.va = 1'b1; tbl[4].stim.ta = t_id;
    tbl[7].stim.vb = 1'b1; tbl[7].stim.tb = t_id;
    tbl[10].stim.va = 1'b1; tbl[10].stim.ta = m_a; tbl[10].stim.vb = 1'b1; tbl[10].stim.tb = m_b;
    tbl[12].exp_err = 1'b1; tbl[12].exp_cause = 2'b01; tbl[12].exp_st = ST_FLAG;
    for (int i = 13; i <= 16; i++) tbl[i].exp_st = ST_BLOCKED;
    tbl[14].stim.va = 1'b1; tbl[14].stim.ta = t_id;
    tbl[16].stim.resume = 1'b1;
    tbl[18].stim.va = 1'b1; tbl[18].stim.ta = t_id;
    tbl[27].exp_err = 1'b1; tbl[27].exp_cause = 2'b10; tbl[27].exp_st = ST_FLAG;
    tbl[27].stim.resume = 1'b1;
    tbl[28].exp_st = ST_BLOCKED; tbl[28].stim.resume = 1'b1;
    for (int i = 29; i <= 32; i++) begin tbl[i].stim.va = 1'b1; tbl[i].stim.ta = t_id; end
    tbl[37].stim.va = 1'b1; tbl[37].stim.ta = t_id;
    tbl[38].exp_err = 1'b1; tbl[38].exp_cause = 2'b11; tbl[38].exp_st = ST_FLAG;
    tbl[39].exp_st = ST_BLOCKED; tbl[40].exp_st = ST_BLOCKED; tbl[40].stim.resume = 1'b1;
    for (int i = 41; i <= 45; i++) begin tbl[i].stim.va = 1'b1; tbl[i].stim.ta = t_id; end
    tbl[46].exp_err = 1'b1; tbl[46].exp_cause = 2'b11; tbl[46].exp_st = ST_FLAG;
    tbl[47].exp_st = ST_BLOCKED; tbl[47].stim.rst = 1'b1;
    tbl[48].stim.va = 1'b1; tbl[48].stim.ta = m_a; tbl[48].stim.vb = 1'b1; tbl[48].stim.tb = m_b;
    tbl[49].stim.rst = 1'b1;

    // power-on reset
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; resume = 1'b0;
    pc_a = '0; pc_b = '0; waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0;
    repeat (2) @(posedge clk);
    v = idle(); v.rst = 1'b1;
    model_step(v);

    for (int i = 0; i < NVEC; i++) begin
      do_cycle(tbl[i].stim, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.vec_err", i),   32'(error_o),   32'(tbl[i].exp_err));
      check($sformatf("tbl%0d.vec_cause", i), 32'(err_cause), 32'(tbl[i].exp_cause));
      check($sformatf("tbl%0d.vec_state", i), 32'(dut_state), 32'(tbl[i].exp_st));
    end

    // B lags A by three cycles: buffers drained two cycles after B's push
    v = idle(); v.va = 1'b1; v.ta = t_id; do_cycle(v, "skew.t0");
    do_cycle(idle(), "skew.t1");
    do_cycle(idle(), "skew.t2");
    v = idle(); v.vb = 1'b1; v.tb = t_id; do_cycle(v, "skew.t3");
    do_cycle(idle(), "skew.t4");
    do_cycle(idle(), "skew.t5");
    check("skew.drained_a", 32'(dut.w_empty_a), 32'd1);
    check("skew.drained_b", 32'(dut.w_empty_b), 32'd1);

    // push into a full buffer while its head pops is not an overflow
    for (int k = 0; k < 4; k++) begin
      v = idle(); v.va = 1'b1; v.ta = gen(k);
      if (k == 3) begin v.vb = 1'b1; v.tb = gen(0); end
      do_cycle(v, $sformatf("fullpp.c%0d", k));
    end
    v = idle(); v.va = 1'b1; v.ta = gen(4); v.vb = 1'b1; v.tb = gen(1);
    do_cycle(v, "fullpp.c4");
    for (int k = 2; k <= 4; k++) begin
      v = idle(); v.vb = 1'b1; v.tb = gen(k);
      do_cycle(v, $sformatf("fullpp.b%0d", k));
    end
    repeat (3) do_cycle(idle(), "fullpp.idle");
    check("fullpp.no_error_state", 32'(dut_state), 32'(ST_RUN));

    // three errors with resume, then reset while halted
    v = idle(); v.rst = 1'b1; do_cycle(v, "cnt.rst");
    for (int k = 0; k < 3; k++) begin
      v = idle(); v.va = 1'b1; v.ta = m_a; v.vb = 1'b1; v.tb = m_b;
      do_cycle(v, "cnt.push");
      do_cycle(idle(), "cnt.cmp");
      do_cycle(idle(), "cnt.flag");
      v = idle(); v.resume = 1'b1; do_cycle(v, "cnt.resume");
    end
    do_cycle(idle(), "cnt.after");
`ifdef FT_ERR_COUNTER_EN
    check("cnt.three", 32'(err_count), 32'd3);
`else
    check("cnt.three", 32'(err_count), 32'd0);
`endif
    v = idle(); v.va = 1'b1; v.ta = m_a; v.vb = 1'b1; v.tb = m_b;
    do_cycle(v, "blkrst.push");
    do_cycle(idle(), "blkrst.cmp");
    do_cycle(idle(), "blkrst.flag");
    v = idle(); v.rst = 1'b1; do_cycle(v, "blkrst.rst");
    do_cycle(idle(), "blkrst.after");
    check("blkrst.state", 32'(dut_state), 32'(ST_RUN));
    check("blkrst.count", 32'(err_count), 32'd0);

    // randomized lockstep streams with occasional corruption, lag and reset
    ia = 0; ib = 0;
    for (int n = 0; n < 3000; n++) begin
      v = idle();
      if (m_phase != 0) begin
        ia = (ia > ib) ? ia : ib;
        ib = ia;
      end
      v.resume = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      v.rst    = ($urandom_range(0, 299) == 0);
      v.va     = ($urandom_range(0, 2) != 0) && ((ia - ib < 4) || ($urandom_range(0, 49) == 0));
      v.vb     = ($urandom_range(0, 2) != 0) && ((ib - ia < 4) || ($urandom_range(0, 49) == 0));
      v.ta     = gen(ia);
      v.tb     = gen(ib);
      if ($urandom_range(0, 99) == 0) v.tb.wd = v.tb.wd ^ (32'd1 << $urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) v.tb.wa = v.tb.wa ^ 5'd1;
      if (v.va) ia++;
      if (v.vb) ib++;
      if (v.rst) begin
        ia = 0; ib = 0;
      end
      do_cycle(v, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
